// File: rtl/mem_write_checker.sv
// Watches data-memory writes during a run and decides pass/fail against a
// table of expected (address, data) entries, in legacy-target or strict-order mode.
module mem_write_checker #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NEXP    = 4,
    parameter int TIMEOUT = 10000,
    parameter int CW      = 32,
    localparam int IW     = $clog2(NEXP + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic              mem_write,
    input  logic [AW-1:0]     data_adr,
    input  logic [DW-1:0]     write_data,
    input  logic [IW-1:0]     exp_count,
    input  logic [NEXP*AW-1:0] exp_addr_flat,
    input  logic [NEXP*DW-1:0] exp_data_flat,
    input  logic [AW-1:0]     ign_addr,
    input  logic [AW-1:0]     ign_mask,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [IW-1:0]     match_idx,
    output logic [CW-1:0]     cycle_cnt,
    output logic [CW-1:0]     write_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    state_t        state_q, state_d;
    logic [IW-1:0] match_idx_q, match_idx_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CW-1:0] write_cnt_q, write_cnt_d;
    logic [1:0]    fail_code_q, fail_code_d;
    logic          busy_q, done_q, pass_q, fail_q;

    logic [IW-1:0] cnt_eff;
    logic [IW-1:0] tgt_idx;
    logic [AW-1:0] cur_addr, tgt_addr;
    logic [DW-1:0] cur_data, tgt_data;
    logic          allowed;
    logic          ignored;
    logic          seq_hit;
    logic          tgt_addr_hit;
    logic          tgt_hit;
    logic          pass_now;
    logic          fail_now;
    logic [1:0]    code_now;

    // Table entries beyond NEXP do not exist, so oversize counts clamp.
    always_comb begin
        cnt_eff = (exp_count > IW'(NEXP)) ? IW'(NEXP) : exp_count;
        tgt_idx = cnt_eff - 1'b1;
    end

    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        tgt_addr = '0;
        tgt_data = '0;
        allowed  = 1'b0;
        for (int i = 0; i < NEXP; i++) begin
            if (IW'(i) == match_idx_q) begin
                cur_addr = exp_addr_flat[i*AW +: AW];
                cur_data = exp_data_flat[i*DW +: DW];
            end
            if (IW'(i) == tgt_idx) begin
                tgt_addr = exp_addr_flat[i*AW +: AW];
                tgt_data = exp_data_flat[i*DW +: DW];
            end
            if ((IW'(i) < tgt_idx) && (data_adr == exp_addr_flat[i*AW +: AW])) begin
                allowed = 1'b1;
            end
        end
    end

    always_comb begin
        ignored      = (ign_mask != '0) && ((data_adr & ign_mask) == (ign_addr & ign_mask));
        seq_hit      = (data_adr == cur_addr) && (write_data == cur_data);
        tgt_addr_hit = (data_adr == tgt_addr);
        tgt_hit      = tgt_addr_hit && (write_data == tgt_data);
    end

    // Classify this cycle's write; only meaningful while in RUN.
    always_comb begin
        pass_now = 1'b0;
        fail_now = 1'b0;
        code_now = FC_NONE;
        if (cnt_eff == '0) begin
            pass_now = 1'b1;
        end else if (mem_write) begin
            if (mode) begin
                if (seq_hit) begin
                    pass_now = (match_idx_q == tgt_idx);
                end else if (!ignored) begin
                    fail_now = 1'b1;
                    code_now = (data_adr != cur_addr) ? FC_ADDR : FC_DATA;
                end
            end else begin
                if (tgt_hit) begin
                    pass_now = 1'b1;
                end else if (ignored) begin
                    fail_now = 1'b0;
                end else if (tgt_addr_hit) begin
                    fail_now = 1'b1;
                    code_now = FC_DATA;
                end else if (!allowed) begin
                    fail_now = 1'b1;
                    code_now = FC_ADDR;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        match_idx_d = match_idx_q;
        cycle_cnt_d = cycle_cnt_q;
        write_cnt_d = write_cnt_q;
        fail_code_d = fail_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    match_idx_d = '0;
                    cycle_cnt_d = '0;
                    write_cnt_d = '0;
                    fail_code_d = FC_NONE;
                end
            end
            S_RUN: begin
                if (mem_write) begin
                    write_cnt_d = write_cnt_q + 1'b1;
                end
                if (mem_write && (cnt_eff != '0) && ((mode && seq_hit) || (!mode && tgt_hit))) begin
                    match_idx_d = match_idx_q + 1'b1;
                end
                // Counter freezes on the exit edge so it reports the last RUN cycle index.
                if (pass_now) begin
                    state_d = S_PASS;
                end else if (fail_now) begin
                    state_d     = S_FAIL;
                    fail_code_d = code_now;
                end else if (cycle_cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = S_FAIL;
                    fail_code_d = FC_TIMEOUT;
                end else if (!(&cycle_cnt_q)) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            S_PASS:  state_d = S_PASS;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            match_idx_q <= '0;
            cycle_cnt_q <= '0;
            write_cnt_q <= '0;
            fail_code_q <= FC_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_idx_q <= match_idx_d;
            cycle_cnt_q <= cycle_cnt_d;
            write_cnt_q <= write_cnt_d;
            fail_code_q <= fail_code_d;
            busy_q      <= (state_d == S_RUN);
            done_q      <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q      <= (state_d == S_PASS);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign match_idx = match_idx_q;
    assign cycle_cnt = cycle_cnt_q;
    assign write_cnt = write_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a driver issues runs and queues the
// expected verdict; a monitor pops and compares whenever done rises.
module tb_mem_write_checker;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NEXP    = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = 32;
    localparam int IW      = 3;
    localparam int EW      = 24;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               mode;
    logic               mem_write;
    logic [AW-1:0]      data_adr;
    logic [DW-1:0]      write_data;
    logic [IW-1:0]      exp_count;
    logic [NEXP*AW-1:0] exp_addr_flat;
    logic [NEXP*DW-1:0] exp_data_flat;
    logic [AW-1:0]      ign_addr;
    logic [AW-1:0]      ign_mask;
    logic               busy, done, pass, fail;
    logic [1:0]         fail_code;
    logic [IW-1:0]      match_idx;
    logic [CW-1:0]      cycle_cnt, write_cnt;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic done_prev = 1'b0;

    // {pass, fail, code[1:0], chk_idx, idx[2:0], write_cnt[7:0], cycle_cnt[7:0]}
    logic [EW-1:0] exp_q[$];

    mem_write_checker #(
        .AW(AW), .DW(DW), .NEXP(NEXP), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .exp_count(exp_count), .exp_addr_flat(exp_addr_flat), .exp_data_flat(exp_data_flat),
        .ign_addr(ign_addr), .ign_mask(ign_mask),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_idx(match_idx), .cycle_cnt(cycle_cnt), .write_cnt(write_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic logic [EW-1:0] mk_exp(input logic p, input logic f, input logic [1:0] code,
                                            input logic chk_idx, input logic [2:0] idx,
                                            input logic [7:0] wc, input logic [7:0] cyc);
        return {p, f, code, chk_idx, idx, wc, cyc};
    endfunction

    // Monitor: a rising done is the DUT presenting its verdict.
    always @(negedge clk) begin
        if (reset_n && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no verdict");
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("verdict_pass", pass, e[23]);
                chk("verdict_fail", fail, e[22]);
                chk("verdict_fail_code", fail_code, e[21:20]);
                if (e[19]) chk("verdict_match_idx", match_idx, e[18:16]);
                chk("verdict_write_cnt", write_cnt, e[15:8]);
                chk("verdict_cycle_cnt", cycle_cnt, e[7:0]);
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_flags"}, {busy, done, pass, fail, fail_code, match_idx, dbg_state}, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_write_cnt"}, write_cnt, 0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        mem_write = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_cleared("reset");
        tick();
    endtask

    task automatic set_entry(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_addr_flat[i*AW +: AW] = a;
        exp_data_flat[i*DW +: DW] = d;
    endtask

    task automatic setup(input logic m, input logic [IW-1:0] n,
                         input logic [AW-1:0] ia, input logic [AW-1:0] im);
        mode          = m;
        exp_count     = n;
        ign_addr      = ia;
        ign_mask      = im;
        exp_addr_flat = '0;
        exp_data_flat = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_write  = 1'b1;
        data_adr   = a;
        write_data = d;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, done, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic strict_table();
        setup(1'b1, 3'd3, 32'h0, 32'h0);
        set_entry(0, 32'd0, 32'd1);
        set_entry(1, 32'd4, 32'd2);
        set_entry(2, 32'd8, 32'd3);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; mem_write = 1'b0;
        data_adr = '0; write_data = '0; exp_count = '0;
        exp_addr_flat = '0; exp_data_flat = '0; ign_addr = '0; ign_mask = '0;

        // Legacy pass: allowed 96 with any data, then target 100<-7.
        do_reset();
        setup(1'b0, 3'd2, 32'h0, 32'h0);
        set_entry(0, 32'd96, 32'd0);
        set_entry(1, 32'd100, 32'd7);
        exp_q.push_back(mk_exp(1, 0, 2'd0, 0, 3'd0, 8'd2, 8'd1));
        pulse_start();
        wr(32'd96, 32'd3);
        wr(32'd100, 32'd7);
        wait_done("legacy_pass_done");

        // Legacy address fail: 104 is not in the table.
        do_reset();
        setup(1'b0, 3'd2, 32'h0, 32'h0);
        set_entry(0, 32'd96, 32'd0);
        set_entry(1, 32'd100, 32'd7);
        exp_q.push_back(mk_exp(0, 1, 2'd1, 1, 3'd0, 8'd1, 8'd0));
        pulse_start();
        wr(32'd104, 32'd7);
        wait_done("legacy_addr_fail_done");

        // Legacy data fail: target address, wrong data.
        do_reset();
        setup(1'b0, 3'd2, 32'h0, 32'h0);
        set_entry(0, 32'd96, 32'd0);
        set_entry(1, 32'd100, 32'd7);
        exp_q.push_back(mk_exp(0, 1, 2'd2, 1, 3'd0, 8'd1, 8'd0));
        pulse_start();
        wr(32'd100, 32'd6);
        wait_done("legacy_data_fail_done");

        // Strict: out-of-order first write.
        do_reset();
        strict_table();
        exp_q.push_back(mk_exp(0, 1, 2'd1, 1, 3'd0, 8'd1, 8'd0));
        pulse_start();
        wr(32'd4, 32'd2);
        wait_done("strict_order_fail_done");

        // Strict: correct order, then writes after PASS must be ignored.
        do_reset();
        strict_table();
        exp_q.push_back(mk_exp(1, 0, 2'd0, 1, 3'd3, 8'd3, 8'd2));
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        wr(32'd8, 32'd3);
        wait_done("strict_pass_done");
        wr(32'h50, 32'd0);
        @(negedge clk);
        chk("terminal_pass_hold", {pass, fail, busy}, 3'b100);
        chk("terminal_write_cnt_hold", write_cnt, 3);
        tick();

        // Strict: right address, wrong data on the second entry.
        do_reset();
        strict_table();
        exp_q.push_back(mk_exp(0, 1, 2'd2, 1, 3'd1, 8'd2, 8'd1));
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd9);
        wait_done("strict_data_fail_done");

        // Ignore window swallows an off-table write mid-sequence.
        do_reset();
        strict_table();
        ign_addr = 32'h200;
        ign_mask = 32'hF00;
        exp_q.push_back(mk_exp(1, 0, 2'd0, 1, 3'd3, 8'd4, 8'd3));
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'h2A4, 32'd5);
        wr(32'd4, 32'd2);
        wr(32'd8, 32'd3);
        wait_done("ignore_pass_done");

        // Timeout with no writes.
        do_reset();
        strict_table();
        exp_q.push_back(mk_exp(0, 1, 2'd3, 1, 3'd0, 8'd0, 8'd7));
        pulse_start();
        wait_done("timeout_fail_done");

        // Final match lands exactly on the timeout cycle: pass wins.
        do_reset();
        strict_table();
        exp_q.push_back(mk_exp(1, 0, 2'd0, 1, 3'd3, 8'd3, 8'd7));
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        idle(5);
        wr(32'd8, 32'd3);
        wait_done("timeout_edge_pass_done");

        // Empty table passes straight away.
        do_reset();
        setup(1'b1, 3'd0, 32'h0, 32'h0);
        exp_q.push_back(mk_exp(1, 0, 2'd0, 1, 3'd0, 8'd0, 8'd0));
        pulse_start();
        wait_done("empty_table_done");

        // Count above NEXP clamps to NEXP entries.
        do_reset();
        setup(1'b1, 3'd7, 32'h0, 32'h0);
        set_entry(0, 32'd0, 32'd1);
        set_entry(1, 32'd4, 32'd2);
        set_entry(2, 32'd8, 32'd3);
        set_entry(3, 32'd12, 32'd4);
        exp_q.push_back(mk_exp(1, 0, 2'd0, 1, 3'd4, 8'd4, 8'd3));
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        wr(32'd8, 32'd3);
        wr(32'd12, 32'd4);
        wait_done("clamp_pass_done");

        // Reset mid-RUN with a simultaneous start, then a full re-run from entry 0.
        do_reset();
        strict_table();
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        @(negedge clk);
        chk("midrun_busy", {busy, match_idx}, {1'b1, 3'd2});
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        check_cleared("midrun_reset");
        tick();
        @(negedge clk);
        chk("start_in_reset_ignored", busy, 0);
        tick();
        exp_q.push_back(mk_exp(1, 0, 2'd0, 1, 3'd3, 8'd3, 8'd2));
        pulse_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        wr(32'd8, 32'd3);
        wait_done("restart_pass_done");

        // Reset out of a terminal state clears everything.
        do_reset();

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter AW, default 32: data-memory address width.
REQ-002 Parameter DW, default 32: data-memory write-data width.
REQ-003 Parameter NEXP, default 4: max expected-write table entries (1..16).
REQ-004 Parameter TIMEOUT, default 10000: cycle budget after start, at least 2.
REQ-005 Parameter CW, default 32: cycle/write counter width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  synchronous reset, active-low.
REQ-008 start  in  1  one-cycle pulse that arms the checker; ignored unless state is IDLE.
REQ-009 mode  in  1  0 = legacy (target write ends test; any non-ignore write off-table fails); 1 = strict ordered sequence.
REQ-010 mem_write  in  1  dmem write strobe, sampled each cycle.
REQ-011 data_adr  in  AW  dmem write address.
REQ-012 write_data  in  DW  dmem write data.
REQ-013 exp_count  in  clog2(NEXP+1)  number of valid table entries; values above NEXP clamp to NEXP.
REQ-014 exp_addr_flat / exp_data_flat  in  NEXP*AW / NEXP*DW  expected table; entry i occupies slice i.
REQ-015 ign_addr, ign_mask  in  AW each  write ignored when (data_adr & ign_mask) == (ign_addr & ign_mask) and mask is nonzero.
REQ-016 busy, done, pass, fail  out  1 each  status flags.
REQ-017 fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout.
REQ-018 match_idx  out  clog2(NEXP+1)  entries matched so far.
REQ-019 cycle_cnt, write_cnt  out  CW each  cycles in RUN; mem_write strobes seen in RUN.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, PASS and FAIL; PASS and FAIL are terminal until reset.
REQ-021 IDLE to RUN occurs on start=1, clearing match_idx, cycle_cnt and write_cnt to 0.
REQ-022 In RUN, cycle_cnt increments by 1 each cycle and saturates at all-ones.
REQ-023 In RUN, write_cnt increments on every mem_write=1, ignored writes included.
REQ-024 A write matches when data_adr == exp_addr[match_idx] and write_data == exp_data[match_idx]; match_idx then increments.
REQ-025 On a match at match_idx == exp_count-1, the FSM enters PASS on the next edge.
REQ-026 Mode 1: a non-ignored, non-matching write enters FAIL with code 1 if the address differs, else code 2.
REQ-027 Mode 0: only entry exp_count-1 is the target; earlier entries are allowed addresses (any data, match_idx unchanged).
REQ-028 Mode 0: a write to the target address with wrong data gives FAIL code 2; any other non-allowed, non-ignored address gives FAIL code 1.
REQ-029 Timeout: in RUN with cycle_cnt == TIMEOUT-1 and no pass condition that cycle, the FSM enters FAIL with code 3.
REQ-030 Simultaneous events: a pass condition and timeout in the same cycle gives PASS; an ignore match takes precedence over a mismatch.
REQ-031 exp_count == 0: the FSM enters PASS on the cycle after start.
REQ-032 busy=1 only in RUN; done=1 in PASS or FAIL; pass and fail are one-hot with done; all are registered outputs.
REQ-033 Counters, match_idx and fail_code hold their values in PASS and FAIL.
REQ-034 mem_write is ignored in IDLE, PASS and FAIL.
REQ-035 The block SHALL be synthesizable, with no initial blocks or delays.

Reset
REQ-036 On a rising edge with reset_n=0, the FSM enters IDLE and all outputs and counters clear to 0, including mid-RUN and in terminal states.
REQ-037 A start pulse in the same cycle as reset_n=0 is ignored.

Verification
REQ-038 Legacy pass: mode=0, table {(96,x),(100,7)}, writes 96<-3 then 100<-7 -> PASS, fail_code 0, write_cnt 2.
REQ-039 Legacy fail: mode=0, same table, write to 104 -> FAIL code 1 one cycle later; write 100<-6 -> FAIL code 2.
REQ-040 Strict order: mode=1, table {(0,1),(4,2),(8,3)}, writes 4<-2 first -> FAIL code 1, match_idx 0; correct order -> PASS, match_idx 3.
REQ-041 Ignore window: ign_addr 0x200, ign_mask 0xF00, write 0x2A4<-5 between valid writes -> no fail, write_cnt includes it.
REQ-042 Timeout: TIMEOUT=8, no writes -> FAIL code 3 with cycle_cnt 7; final match on the timeout cycle -> PASS.
REQ-043 Reset mid-RUN: reset_n low for 1 cycle after 2 matches -> IDLE, all outputs 0; a re-start then re-checks from entry 0.
